// File: rtl/inv_cipher_feeder.sv
// inv_cipher_feeder: packs four ciphertext words and the key for the inverse-cipher core, runs the core, returns the plaintext.
// Define INV_FEEDER_WORD_SWAP_EN to load the first word into the LSBs of the core state.
module inv_cipher_feeder #(
  parameter int NK = 4,
  parameter int LATENCY = (NK + 7) * 5 + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_word,
  input  logic [NK*32-1:0]  key_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      out_block,
  output logic              busy,
  output logic              core_reset,
  output logic              core_enable,
  output logic [127:0]      core_state,
  output logic [NK*32:0]    core_key,
  input  logic [127:0]      core_result
);
  localparam int CW = $clog2(LATENCY + 1);
  typedef enum logic [2:0] {LOAD, CORE_RST, RUN, CAPTURE, OUT} state_t;
  state_t state;
  logic [1:0] word_cnt;
  logic [CW-1:0] cycle_cnt;
  logic [6:0] base;
  logic accept;
  always_comb begin
    base = {word_cnt, 5'd0};
    accept = in_valid && in_ready;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= LOAD;
      word_cnt <= '0;
      cycle_cnt <= '0;
      in_ready <= 1'b1;
      busy <= 1'b0;
      core_reset <= 1'b0;
      core_enable <= 1'b0;
      out_valid <= 1'b0;
      out_block <= '0;
      core_state <= '0;
      core_key <= '0;
    end else
      case (state)
        LOAD: if (accept) begin
`ifdef INV_FEEDER_WORD_SWAP_EN
          core_state[base +: 32] <= in_word;
`else
          core_state[7'd127 - base -: 32] <= in_word;
`endif
          word_cnt <= word_cnt + 2'd1;
          if (word_cnt == 2'd3) begin
            core_key <= {1'b0, key_in};
            state <= CORE_RST;
            in_ready <= 1'b0;
            busy <= 1'b1;
            core_reset <= 1'b1;
          end
        end
        CORE_RST: begin
          state <= RUN;
          core_reset <= 1'b0;
          core_enable <= 1'b1;
          cycle_cnt <= CW'(LATENCY - 1);
        end
        RUN: if (cycle_cnt == '0) begin
          state <= CAPTURE;
          core_enable <= 1'b0;
        end else cycle_cnt <= cycle_cnt - 1'b1;
        CAPTURE: begin
          state <= OUT;
          out_block <= core_result;
          out_valid <= 1'b1;
        end
        OUT: if (out_ready) begin
          state <= LOAD;
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          busy <= 1'b0;
          word_cnt <= '0;
        end
        default: state <= LOAD;
      endcase
endmodule

// File: tb/tb_inv_cipher_feeder.sv
// tb_inv_cipher_feeder: directed AES-128 vectors against a cycle-counting core stub, checked through a scoreboard queue.
module tb_inv_cipher_feeder;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  logic clk = 0, reset = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, busy, core_reset, core_enable;
  logic [31:0] in_word = '0;
  logic [127:0] key_in = '0, out_block, core_state, core_result;
  logic [128:0] core_key;
  logic [31:0] words [4];
  logic [127:0] exp_q [$];
  int checks = 0, errors = 0, cyc = 0, t4 = 0, ccnt = 0;
  int en_cnt = 0, rst_cnt = 0, both_cnt = 0;

  inv_cipher_feeder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .key_in(key_in), .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
    .busy(busy), .core_reset(core_reset), .core_enable(core_enable), .core_state(core_state),
    .core_key(core_key), .core_result(core_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Core stub: the plaintext appears only after exactly 56 enable cycles since the last core reset.
  always @(posedge clk)
    if (core_reset) ccnt <= 0;
    else if (core_enable) ccnt <= ccnt + 1;
  assign core_result = (ccnt == 56) ?
    ((core_state == CT && core_key == {1'b0, KEY}) ? PT : core_state ^ core_key[127:0]) : 128'h0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (core_enable) en_cnt++;
    if (core_reset) rst_cnt++;
    if (core_enable && core_reset) both_cnt++;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop: got block %0h with nothing expected", out_block);
      end else check("pop_block", out_block, exp_q.pop_front());
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_block(input bit stall, input bit push);
    for (int k = 0; k < 4; k++) begin
      in_valid = 0;
      repeat (stall ? k : 0) tick();
      in_valid = 1;
      in_word = words[k];
      key_in = (k == 3) ? KEY : ~KEY;
      for (int i = 0; i < 200 && !in_ready; i++) tick();
      check("in_ready_wait", in_ready, 1);
      tick();
    end
    in_valid = 0;
    key_in = ~KEY;
    t4 = cyc;
    if (push) exp_q.push_back(PT);
  endtask

  task automatic wait_valid;
    for (int i = 0; i < 300 && !out_valid; i++) tick();
    check("out_valid_wait", out_valid, 1);
  endtask

  task automatic pop_one;
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  initial begin
    int e0, r0, bad;
`ifdef INV_FEEDER_WORD_SWAP_EN
    words = '{32'h70b4c55a, 32'hd8cdb780, 32'h6a7b0430, 32'h69c4e0d8};
`else
    words = '{32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a};
`endif
    #2 reset = 1;
    repeat (3) tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_core_reset", core_reset, 0);
    check("rst_core_enable", core_enable, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_block", out_block, 0);
    check("rst_core_state", core_state, 0);
    check("rst_core_key", core_key, 0);
    reset = 0;
    tick();
    // vector 1, no gaps
    e0 = en_cnt;
    r0 = rst_cnt;
    send_block(0, 1);
    check("v1_core_state", core_state, CT);
    check("v1_core_key", core_key, {1'b0, KEY});
    check("v1_busy", busy, 1);
    check("v1_in_ready", in_ready, 0);
    wait_valid();
    check("v1_latency", cyc - t4, 58);
    check("v1_out_block", out_block, PT);
    check("v1_enable_cycles", en_cnt - e0, 56);
    pop_one();
    check("v1_in_ready_after_pop", in_ready, 1);
    // input stalls of 0..3 cycles
    r0 = rst_cnt;
    send_block(1, 1);
    bad = 0;
    for (int i = 0; i < 300 && !out_valid; i++) begin
      if (in_ready) bad++;
      tick();
    end
    check("stall_out_valid", out_valid, 1);
    check("stall_in_ready_low", bad, 0);
    check("stall_core_reset_pulses", rst_cnt - r0, 1);
    pop_one();
    // output backpressure for 20 cycles with a pending new word
    e0 = en_cnt;
    send_block(0, 1);
    wait_valid();
    in_valid = 1;
    in_word = 32'hdeadbeef;
    bad = 0;
    repeat (20) begin
      tick();
      if (!out_valid || out_block !== PT || in_ready || core_state !== CT) bad++;
    end
    in_valid = 0;
    check("bp_held_stable", bad, 0);
    check("bp_enable_cycles", en_cnt - e0, 56);
    pop_one();
    check("bp_in_ready_after_pop", in_ready, 1);
    check("bp_out_valid_after_pop", out_valid, 0);
    // reset in the middle of RUN
    send_block(0, 0);
    repeat (31) tick();
    check("mid_run_enable", core_enable, 1);
    #2 reset = 1;
    #1;
    check("mid_rst_core_enable", core_enable, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_core_state", core_state, 0);
    check("mid_rst_core_key", core_key, 0);
    check("mid_rst_in_ready", in_ready, 1);
    tick();
    reset = 0;
    tick();
    send_block(0, 1);
    wait_valid();
    check("post_rst_latency", cyc - t4, 58);
    pop_one();
    // back-to-back with out_ready tied high
    out_ready = 1;
    for (int b = 0; b < 2; b++) begin
      send_block(0, 1);
      wait_valid();
      check("b2b_in_ready_before_pop", in_ready, 0);
      tick();
      check("b2b_in_ready_after_pop", in_ready, 1);
      check("b2b_out_valid_after_pop", out_valid, 0);
    end
    out_ready = 0;
    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    check("reset_enable_overlap", both_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
